gb_mbc_mapper: RTL and testbench

- Parametrised Game Boy memory bank controller; successor to the fixed 3-bit ROM-bank logic in the cartridge top.
- Supports MBC1 and MBC5 register maps, configurable ROM/RAM sizes, external-RAM enable/banking and MBC1 banking mode.
- Sits between the synchronised cartridge bus and the SPRAM/RAM arrays.
- Produces physical ROM/RAM byte addresses, read/write strobes, bus drive enable and current bank for LED display.

---
 rtl/gb_mbc_mapper.sv | 100 ++++++++++
 tb/tb_gb_mbc_mapper.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gb_mbc_mapper.sv
// gb_mbc_mapper: MBC1/MBC5 bank controller mapping the synchronised cartridge bus onto ROM/RAM addresses
module gb_mbc_mapper #(
  parameter int MBC_TYPE      = 1,
  parameter int ROM_SIZE_LOG2 = 17,
  parameter int RAM_SIZE_LOG2 = 13,
  parameter int SYNC_STAGES   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [15:0]              bus_A,
  input  logic [7:0]               bus_D_in,
  input  logic                     bus_nWR,
  input  logic                     bus_nRD,
  output logic [ROM_SIZE_LOG2-1:0] rom_addr,
  output logic                     rom_rd,
  output logic [RAM_SIZE_LOG2-1:0] ram_addr,
  output logic                     ram_rd,
  output logic                     ram_wr,
  output logic [7:0]               ram_wdata,
  output logic                     data_oe,
  output logic [8:0]               rom_bank,
  output logic                     ram_enabled
);
  if (MBC_TYPE != 1 && MBC_TYPE != 5) begin : g_bad_type
    $error("gb_mbc_mapper: MBC_TYPE must be 1 or 5");
  end
  localparam bit IS_MBC1 = (MBC_TYPE == 1);
  localparam logic [8:0] ROM_MASK = 9'((1 << (ROM_SIZE_LOG2 - 14)) - 1);
  localparam logic [3:0] RAM_MASK = 4'((1 << (RAM_SIZE_LOG2 - 13)) - 1);
  logic [25:0] sync_q [SYNC_STAGES];
  logic        nwr_q;
  logic [15:0] a_s;
  logic [7:0]  d_s;
  logic        nwr_s, nrd_s, wc, ram_sel;
  logic        ram_en_r, mode, bank8;
  logic [7:0]  bank_lo;
  logic [1:0]  bank_hi;
  logic [3:0]  ram_bank;
  logic [8:0]  bank_4000, bank_cur;
  logic [3:0]  ram_bank_eff;
  assign {a_s, d_s, nwr_s, nrd_s} = sync_q[SYNC_STAGES-1];
  assign wc        = enable & ~nwr_q & nwr_s;
  assign ram_sel   = a_s[15:13] == 3'b101;
  assign bank_4000 = ROM_MASK & (IS_MBC1 ? {2'b0, bank_hi, bank_lo[4:0]} : {bank8, bank_lo});
  assign bank_cur  = a_s[14] ? bank_4000 : ROM_MASK & ((IS_MBC1 && mode) ? {2'b0, bank_hi, 5'b0} : 9'd0);
  assign ram_bank_eff = RAM_MASK & (IS_MBC1 ? (mode ? {2'b0, bank_hi} : 4'd0) : ram_bank);
  // Bring the asynchronous bus into the clock domain; the extra nWR flop gives the rising-edge detect
  always_ff @(posedge clk) begin
    sync_q[0] <= {bus_A, bus_D_in, bus_nWR, bus_nRD};
    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    nwr_q <= nwr_s;
  end
  // Bank/control register file, updated on a committed write below 8000
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_en_r <= 1'b0;
      bank_lo  <= 8'd1;
      bank_hi  <= 2'd0;
      bank8    <= 1'b0;
      mode     <= 1'b0;
      ram_bank <= 4'd0;
    end else if (wc && !a_s[15]) begin
      if (a_s[14:13] == 2'b00) ram_en_r <= d_s[3:0] == 4'hA;
      else if (IS_MBC1) begin
        if (a_s[14:13] == 2'b01) bank_lo <= {3'b0, (d_s[4:0] == 5'd0) ? 5'd1 : d_s[4:0]};
        else if (a_s[14:13] == 2'b10) bank_hi <= d_s[1:0];
        else mode <= d_s[0];
      end else begin
        if (a_s[14:12] == 3'b010) bank_lo <= d_s;
        else if (a_s[14:12] == 3'b011) bank8 <= d_s[0];
        else if (a_s[14:13] == 2'b10) ram_bank <= d_s[3:0];
      end
    end
  end
  // Registered address translation and strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr    <= '0;
      ram_addr    <= '0;
      rom_rd      <= 1'b0;
      ram_rd      <= 1'b0;
      ram_wr      <= 1'b0;
      ram_wdata   <= 8'd0;
      data_oe     <= 1'b0;
      rom_bank    <= 9'd0;
      ram_enabled <= 1'b0;
    end else begin
      rom_addr    <= ROM_SIZE_LOG2'({bank_cur, a_s[13:0]});
      ram_addr    <= RAM_SIZE_LOG2'({ram_bank_eff, a_s[12:0]});
      rom_rd      <= enable & ~nrd_s & ~a_s[15];
      ram_rd      <= enable & ~nrd_s & ram_sel & ram_en_r;
      ram_wr      <= wc & ram_sel & ram_en_r;
      ram_wdata   <= d_s;
      data_oe     <= enable & ~nrd_s & (~a_s[15] | (ram_sel & ram_en_r));
      rom_bank    <= bank_4000;
      ram_enabled <= ram_en_r;
    end
  end
endmodule

// File: tb/tb_gb_mbc_mapper.sv
// tb_gb_mbc_mapper: randomized and directed checks of three mapper configurations against a reference model
module tb_gb_mbc_mapper;
  localparam int SS = 4;
  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [15:0] bus_A = 16'd0;
  logic [7:0]  bus_D_in = 8'd0;
  logic        bus_nWR = 1'b1, bus_nRD = 1'b1;
  logic [16:0] rom_addr0;
  logic [20:0] rom_addr1;
  logic [22:0] rom_addr2;
  logic [12:0] ram_addr0;
  logic [14:0] ram_addr1;
  logic [16:0] ram_addr2;
  logic        rom_rd [3], ram_rd [3], ram_wr [3], data_oe [3], ram_enabled [3];
  logic [7:0]  ram_wdata [3];
  logic [8:0]  rom_bank [3];
  int n_chk = 0, n_err = 0;
  int mt [3] = '{1, 1, 5};
  int rl [3] = '{17, 21, 23};
  int al [3] = '{13, 15, 17};
  int m_en [3], m_lo [3], m_hi [3], m_b8 [3], m_md [3], m_rb [3];
  always #25 clk = ~clk;
  gb_mbc_mapper #(.MBC_TYPE(1), .ROM_SIZE_LOG2(17), .RAM_SIZE_LOG2(13), .SYNC_STAGES(SS)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .bus_A(bus_A), .bus_D_in(bus_D_in),
    .bus_nWR(bus_nWR), .bus_nRD(bus_nRD), .rom_addr(rom_addr0), .rom_rd(rom_rd[0]),
    .ram_addr(ram_addr0), .ram_rd(ram_rd[0]), .ram_wr(ram_wr[0]), .ram_wdata(ram_wdata[0]),
    .data_oe(data_oe[0]), .rom_bank(rom_bank[0]), .ram_enabled(ram_enabled[0]));
  gb_mbc_mapper #(.MBC_TYPE(1), .ROM_SIZE_LOG2(21), .RAM_SIZE_LOG2(15), .SYNC_STAGES(SS)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .bus_A(bus_A), .bus_D_in(bus_D_in),
    .bus_nWR(bus_nWR), .bus_nRD(bus_nRD), .rom_addr(rom_addr1), .rom_rd(rom_rd[1]),
    .ram_addr(ram_addr1), .ram_rd(ram_rd[1]), .ram_wr(ram_wr[1]), .ram_wdata(ram_wdata[1]),
    .data_oe(data_oe[1]), .rom_bank(rom_bank[1]), .ram_enabled(ram_enabled[1]));
  gb_mbc_mapper #(.MBC_TYPE(5), .ROM_SIZE_LOG2(23), .RAM_SIZE_LOG2(17), .SYNC_STAGES(SS)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .bus_A(bus_A), .bus_D_in(bus_D_in),
    .bus_nWR(bus_nWR), .bus_nRD(bus_nRD), .rom_addr(rom_addr2), .rom_rd(rom_rd[2]),
    .ram_addr(ram_addr2), .ram_rd(ram_rd[2]), .ram_wr(ram_wr[2]), .ram_wdata(ram_wdata[2]),
    .data_oe(data_oe[2]), .rom_bank(rom_bank[2]), .ram_enabled(ram_enabled[2]));
  function automatic logic [31:0] rom_a(int k);
    return k == 0 ? {15'b0, rom_addr0} : k == 1 ? {11'b0, rom_addr1} : {9'b0, rom_addr2};
  endfunction
  function automatic logic [31:0] ram_a(int k);
    return k == 0 ? {19'b0, ram_addr0} : k == 1 ? {17'b0, ram_addr1} : {15'b0, ram_addr2};
  endfunction
  function automatic logic [31:0] b32(logic b);
    return {31'b0, b};
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset;
    for (int k = 0; k < 3; k++) begin
      m_en[k] = 0; m_lo[k] = 1; m_hi[k] = 0; m_b8[k] = 0; m_md[k] = 0; m_rb[k] = 0;
    end
  endtask
  function automatic int in_ram(int a);
    return (a >= 'hA000 && a < 'hC000) ? 1 : 0;
  endfunction
  function automatic int exp_bank4(int k);
    int b = mt[k] == 1 ? m_hi[k] * 32 + m_lo[k] : m_b8[k] * 256 + m_lo[k];
    return b % (1 << (rl[k] - 14));
  endfunction
  function automatic int exp_rom(int k, int a);
    int nb = 1 << (rl[k] - 14);
    int b = a >= 'h4000 ? exp_bank4(k) : ((mt[k] == 1 && m_md[k] != 0) ? (m_hi[k] * 32) % nb : 0);
    return (b * 16384 + a % 16384) % (1 << rl[k]);
  endfunction
  function automatic int exp_ram(int k, int a);
    int rb = mt[k] == 1 ? (m_md[k] != 0 ? m_hi[k] : 0) : m_rb[k];
    return (rb % (1 << (al[k] - 13))) * 8192 + a % 8192;
  endfunction
  task automatic model_write(int a, int d);
    for (int k = 0; k < 3; k++) begin
      if (a < 'h2000) m_en[k] = (d % 16 == 10) ? 1 : 0;
      else if (a >= 'h8000) ;
      else if (mt[k] == 1) begin
        if (a < 'h4000) m_lo[k] = (d % 32 == 0) ? 1 : d % 32;
        else if (a < 'h6000) m_hi[k] = d % 4;
        else m_md[k] = d % 2;
      end else begin
        if (a < 'h3000) m_lo[k] = d;
        else if (a < 'h4000) m_b8[k] = d % 2;
        else if (a < 'h6000) m_rb[k] = d % 16;
      end
    end
  endtask
  task automatic do_write(int a, int d, bit drop_en);
    int cnt [3];
    logic [31:0] wd [3], wa [3];
    int pulse;
    @(negedge clk);
    bus_A = 16'(a); bus_D_in = 8'(d); bus_nWR = 1'b0; bus_nRD = 1'b1;
    repeat (3) @(negedge clk);
    if (drop_en) enable = 1'b0;
    bus_nWR = 1'b1;
    for (int k = 0; k < 3; k++) begin cnt[k] = 0; wd[k] = '0; wa[k] = '0; end
    repeat (10) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (ram_wr[k] === 1'b1) begin cnt[k]++; wd[k] = {24'b0, ram_wdata[k]}; wa[k] = ram_a(k); end
    end
    for (int k = 0; k < 3; k++) begin
      pulse = (enable && in_ram(a) != 0 && m_en[k] != 0) ? 1 : 0;
      chk($sformatf("wr_pulses[%0d]@%0h", k, a), cnt[k], pulse);
      if (pulse != 0) begin
        chk($sformatf("wr_data[%0d]", k), wd[k], d);
        chk($sformatf("wr_addr[%0d]", k), wa[k], exp_ram(k, a));
      end
    end
    if (enable) model_write(a, d);
    if (drop_en) enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rom_bank[%0d]", k), {23'b0, rom_bank[k]}, exp_bank4(k));
      chk($sformatf("ram_enabled[%0d]", k), b32(ram_enabled[k]), m_en[k]);
    end
  endtask
  task automatic do_read(int a);
    int er, ea;
    @(negedge clk);
    bus_A = 16'(a); bus_nRD = 1'b0; bus_nWR = 1'b1;
    repeat (SS) @(posedge clk);
    #1 chk("oe_too_early", b32(data_oe[0]), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      er = (enable && a < 'h8000) ? 1 : 0;
      ea = (enable && in_ram(a) != 0 && m_en[k] != 0) ? 1 : 0;
      chk($sformatf("rom_rd[%0d]@%0h", k, a), b32(rom_rd[k]), er);
      chk($sformatf("ram_rd[%0d]@%0h", k, a), b32(ram_rd[k]), ea);
      chk($sformatf("data_oe[%0d]@%0h", k, a), b32(data_oe[k]), er | ea);
      if (a < 'h8000) chk($sformatf("rom_addr[%0d]@%0h", k, a), rom_a(k), exp_rom(k, a));
      chk($sformatf("ram_addr[%0d]@%0h", k, a), ram_a(k), exp_ram(k, a));
    end
    @(negedge clk);
    bus_nRD = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  int bases [8] = '{'h0000, 'h2000, 'h3000, 'h4000, 'h6000, 'hA000, 'h8000, 'hC000};
  initial begin
    int a, d;
    model_reset();
    repeat (8) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rom_bank[%0d]", k), {23'b0, rom_bank[k]}, 0);
      chk($sformatf("rst_rom_rd[%0d]", k), b32(rom_rd[k]), 0);
      chk($sformatf("rst_oe[%0d]", k), b32(data_oe[k]), 0);
      chk($sformatf("rst_ram_en[%0d]", k), b32(ram_enabled[k]), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    do_write('h2100, 'h00, 0);
    do_read('h4000);
    chk("tp_bank1_addr", rom_a(0), 'h04000);
    do_write('h2000, 'h1F, 0);
    chk("tp_bank_masked", {23'b0, rom_bank[0]}, 7);
    do_read('h7FFF);
    chk("tp_addr_7fff", rom_a(0), 'h1FFFF);
    do_write('h2000, 'h20, 0);
    chk("tp_zero_low5", {23'b0, rom_bank[0]}, 1);
    do_write('h6000, 'h01, 0);
    do_write('h4000, 'h02, 0);
    do_read('h0000);
    chk("tp_mode1_rom", rom_a(1), 'h100000);
    do_read('hA000);
    chk("tp_mode1_ram", ram_a(1), 'h4000);
    do_write('h6000, 'h00, 0);
    do_write('h0000, 'h0A, 0);
    do_write('hA123, 'h5A, 0);
    do_write('h0000, 'h00, 0);
    do_write('hA123, 'h33, 0);
    do_read('hA123);
    chk("tp_ram_off_oe", b32(data_oe[0]), 0);
    do_write('h2000, 'h00, 0);
    do_write('h3000, 'h01, 0);
    chk("tp_mbc5_bank", {23'b0, rom_bank[2]}, 'h100);
    do_read('h4000);
    chk("tp_mbc5_addr", rom_a(2), 'h400000);
    do_write('h3000, 'h00, 0);
    do_read('h4000);
    chk("tp_mbc5_bank0", rom_a(2), 'h000000);
    enable = 1'b0;
    do_write('h2000, 'h03, 0);
    do_write('h0000, 'h0A, 0);
    do_read('h4000);
    enable = 1'b1;
    do_write('h2000, 'h06, 1);
    do_write('h0000, 'h0A, 0);
    do_write('h2000, 'h05, 0);
    @(negedge clk);
    bus_A = 16'h2000; bus_D_in = 8'h03; bus_nWR = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus_nWR = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("midrst_bank[%0d]", k), {23'b0, rom_bank[k]}, 0);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (8) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("postrst_bank[%0d]", k), {23'b0, rom_bank[k]}, exp_bank4(k));
      chk($sformatf("postrst_ram_en[%0d]", k), b32(ram_enabled[k]), 0);
    end
    do_read('h4000);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        a = bases[$urandom_range(0, 7)] + int'($urandom_range(0, 'hFFF));
        d = ($urandom_range(0, 3) == 0) ? 'h0A : int'($urandom_range(0, 255));
        do_write(a, d, 0);
      end else begin
        a = ($urandom_range(0, 3) == 0) ? 'hA000 + int'($urandom_range(0, 'h1FFF)) : int'($urandom_range(0, 'h7FFF));
        do_read(a);
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
